// File: rtl/modport_ram.sv
// Simple dual-port RAM that zero-fills itself after reset, then serves one write
// and one registered read per cycle with write-first bypass on address collision.
module modport_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  ready,
  output logic                  state_dbg
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_ptr_q, init_ptr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic                    wr_accept;
  logic                    rd_accept;
  logic                    bypass;

  // Requests are only honoured once the clear sweep has finished.
  assign wr_accept = (state_q == RUN) && write;
  assign rd_accept = (state_q == RUN) && read;
  assign bypass    = wr_accept && rd_accept && (wr_address == rd_address);

  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_address;
    mem_wdata    = data_in;
    case (state_q)
      INIT: begin
        mem_we     = !reset;
        mem_waddr  = init_ptr_q;
        mem_wdata  = '0;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        mem_we = wr_accept && !reset;
        if (rd_accept) begin
          data_out_d   = bypass ? data_in : mem[rd_address];
          data_valid_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= INIT;
      init_ptr_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage itself has no reset; the INIT sweep provides the cleared contents.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign ready      = (state_q == RUN);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_modport_ram.sv
// Bench for modport_ram: init timing, directed vector table, randomized traffic
// against an array model, full fill/readback and reset-in-RUN clear.
module tb_modport_ram;

  localparam int DW    = 64;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic          write;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] data_in;
  logic          read;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          ready;
  logic          state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_exp;

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rd;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_d;
    logic          exp_v;
  } vec_t;

  vec_t vecs [8];

  modport_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .write      (write),
    .wr_address (wr_address),
    .data_in    (data_in),
    .read       (read),
    .rd_address (rd_address),
    .data_out   (data_out),
    .data_valid (data_valid),
    .ready      (ready),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rd, input logic [AW-1:0] ra);
    write = wr; wr_address = wa; data_in = wd; read = rd; rd_address = ra;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic wait_ready(input string name);
    int cycles;
    cycles = 0;
    while (!ready && cycles < 5000) begin
      drive(1'b1, AW'($urandom_range(0, DEPTH-1)), {$urandom, $urandom},
            1'b1, AW'($urandom_range(0, DEPTH-1)));
      tick();
      cycles++;
    end
    idle();
    check(name, 64'(cycles), 64'd4096);
  endtask

  // model step: read result is computed from spec rules, then the write is applied
  task automatic model_cycle(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic rd, input logic [AW-1:0] ra);
    if (rd) last_exp = (wr && wa == ra) ? wd : model_mem[ra];
    exp_q.push_back(last_exp);
    if (wr) model_mem[wa] = wd;
  endtask

  initial begin
    vecs[0] = '{1'b1, 12'h005, 64'hDEADBEEF_CAFEF00D, 1'b0, 12'h000, 64'h0, 1'b0};
    vecs[1] = '{1'b0, 12'h000, 64'h0, 1'b1, 12'h005, 64'hDEADBEEF_CAFEF00D, 1'b1};
    vecs[2] = '{1'b1, 12'h0FF, 64'h1234, 1'b1, 12'h0FF, 64'h1234, 1'b1};
    vecs[3] = '{1'b0, 12'h000, 64'h0, 1'b0, 12'h000, 64'h1234, 1'b0};
    vecs[4] = '{1'b1, 12'h010, 64'h55, 1'b1, 12'h005, 64'hDEADBEEF_CAFEF00D, 1'b1};
    vecs[5] = '{1'b0, 12'h000, 64'h0, 1'b1, 12'h010, 64'h55, 1'b1};
    vecs[6] = '{1'b1, 12'h010, 64'h66, 1'b1, 12'h010, 64'h66, 1'b1};
    vecs[7] = '{1'b0, 12'h000, 64'h0, 1'b1, 12'h0FF, 64'h1234, 1'b1};

    reset = 1'b1;
    idle();
    tick();
    tick();
    check("reset_data_out", data_out, '0);
    check("reset_valid", 64'(data_valid), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    reset = 1'b0;

    // requests held high during INIT must be ignored
    wait_ready("init_cycles");
    check("post_init_data_out", data_out, '0);
    check("post_init_valid", 64'(data_valid), 64'd0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    begin
      int addrs [3];
      addrs = '{0, 2047, 4095};
      foreach (addrs[k]) begin
        drive(1'b0, '0, '0, 1'b1, AW'(addrs[k]));
        tick();
        check("init_zero_data", data_out, '0);
        check("init_zero_valid", 64'(data_valid), 64'd1);
      end
    end
    last_exp = '0;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].ra);
      model_cycle(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].ra);
      void'(exp_q.pop_back());
      tick();
      check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_d);
      check($sformatf("vec%0d_valid", i), 64'(data_valid), 64'(vecs[i].exp_v));
    end
    idle();

    // randomized traffic; narrow address window forces collisions
    for (int i = 0; i < 2000; i++) begin
      logic wr, rd;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd, exp_d;
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      drive(wr, wa, wd, rd, ra);
      model_cycle(wr, wa, wd, rd, ra);
      tick();
      exp_d = exp_q.pop_front();
      check("rand_data", data_out, exp_d);
      check("rand_valid", 64'(data_valid), 64'(rd));
    end
    idle();

    // fill every word with its address, then stream reads back to back
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, AW'(a), 64'(a), 1'b0, '0);
      tick();
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(a));
      tick();
      check("fill_data", data_out, 64'(a));
      check("fill_valid", 64'(data_valid), 64'd1);
    end
    idle();
    tick();
    check("fill_valid_drop", 64'(data_valid), 64'd0);
    check("fill_hold", data_out, 64'(DEPTH-1));

    // reset while running wipes contents and restarts the full sweep
    drive(1'b1, 12'h007, 64'hA5, 1'b0, '0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rerun_ready_drop", 64'(ready), 64'd0);
    check("rerun_data_out", data_out, '0);
    check("rerun_valid", 64'(data_valid), 64'd0);
    wait_ready("rerun_init_cycles");
    drive(1'b0, '0, '0, 1'b1, 12'h007);
    tick();
    check("rerun_addr7", data_out, '0);
    check("rerun_addr7_valid", 64'(data_valid), 64'd1);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
